cache_ctrl_fsm_param: RTL

- Parametrised successor controller FSM for the direct-mapped, write-through data cache.
- Owns the tag/valid array internally.
- Decides hit/miss for each CPU request and sequences the main-memory handshake.
- Drives the cache data-array strobes (refill, update).
- Adds a multi-cycle flush (invalidate-all) sequence with an internal line counter.

---
 rtl/cache_ctrl_fsm_param.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/cache_ctrl_fsm_param.sv
// cache_ctrl_fsm_param: controller for a direct-mapped, write-through data cache.
// Owns the tag/valid array, decides hit/miss, sequences the main-memory
// handshake, drives the data-array strobes and runs a multi-cycle flush.
// Optional feature macro: CACHE_WRITE_ALLOCATE_EN (write miss installs the line).
module cache_ctrl_fsm_param #(
  parameter int unsigned INDEX_W = 5,
  parameter int unsigned TAG_W   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [INDEX_W-1:0] index,
  input  logic [TAG_W-1:0]   tag,
  input  logic               flush,
  input  logic               ready,
  output logic               stall,
  output logic               main_read,
  output logic               main_write,
  output logic               refill,
  output logic               update,
  output logic               hit
);

  localparam int unsigned LINES = 1 << INDEX_W;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP_RD = 3'd1,
    LOOKUP_WR = 3'd2,
    MISS_RD   = 3'd3,
    REFILL    = 3'd4,
    WR_MAIN   = 3'd5,
    FLUSH     = 3'd6
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [INDEX_W-1:0] idx_r;
  logic [TAG_W-1:0]   tag_r;
  logic [INDEX_W-1:0] cnt;
  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tag_array [LINES];

  logic lookup_hit;
  logic accept;
  logic set_line;
  logic clr_line;

  // Tag compare against the registered request.
  assign lookup_hit = valid[idx_r] && (tag_array[idx_r] == tag_r);

  // State, request capture, valid bits and flush counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      valid <= '0;
      cnt   <= '0;
      idx_r <= '0;
      tag_r <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        idx_r <= index;
        tag_r <= tag;
      end
      if (set_line) begin
        valid[idx_r] <= 1'b1;
      end
      if (clr_line) begin
        valid[cnt] <= 1'b0;
        cnt        <= cnt + INDEX_W'(1);
      end
    end
  end

  // Tag storage; validity is tracked separately, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (!reset && set_line) begin
      tag_array[idx_r] <= tag_r;
    end
  end

  // Next-state and output decode from the registered state.
  always_comb begin
    state_nxt  = state;
    stall      = 1'b0;
    main_read  = 1'b0;
    main_write = 1'b0;
    refill     = 1'b0;
    update     = 1'b0;
    hit        = 1'b0;
    accept     = 1'b0;
    set_line   = 1'b0;
    clr_line   = 1'b0;
    unique case (state)
      IDLE: begin
        if (flush) begin
          state_nxt = FLUSH;
        end else if (mem_read && !mem_write) begin
          state_nxt = LOOKUP_RD;
          accept    = 1'b1;
        end else if (mem_write && !mem_read) begin
          state_nxt = LOOKUP_WR;
          accept    = 1'b1;
        end
      end
      LOOKUP_RD: begin
        if (lookup_hit) begin
          hit       = 1'b1;
          state_nxt = IDLE;
        end else begin
          stall     = 1'b1;
          state_nxt = MISS_RD;
        end
      end
      MISS_RD: begin
        stall     = 1'b1;
        main_read = 1'b1;
        if (ready) begin
          state_nxt = REFILL;
        end
      end
      REFILL: begin
        stall     = 1'b1;
        refill    = 1'b1;
        set_line  = 1'b1;
        state_nxt = IDLE;
      end
      LOOKUP_WR: begin
        stall     = 1'b1;
        state_nxt = WR_MAIN;
        if (lookup_hit) begin
          hit    = 1'b1;
          update = 1'b1;
        end else begin
`ifdef CACHE_WRITE_ALLOCATE_EN
          update   = 1'b1;
          set_line = 1'b1;
`else
          update   = 1'b0;
`endif
        end
      end
      WR_MAIN: begin
        stall      = 1'b1;
        main_write = 1'b1;
        if (ready) begin
          state_nxt = IDLE;
        end
      end
      FLUSH: begin
        stall    = 1'b1;
        clr_line = 1'b1;
        if (cnt == INDEX_W'(LINES - 1)) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
